decode_issue_queue: RTL

//  Sequences fetched instructions into the decode stage and hands them to execute.

---
 rtl/decode_issue_queue_pkg.sv | 61 ++++++
 rtl/decode_issue_queue_immdec.sv | 37 +++
 rtl/decode_issue_queue.sv | 123 ++++++++++++
 3 files changed

// File: rtl/decode_issue_queue_pkg.sv
// Shared decode definitions: opcodes, instruction formats and
// the opcode classifier used by the issue queue and immediate decoder.
package decode_issue_queue_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  // Unknown opcodes fall back to the I layout.
  function automatic fmt_e op_fmt(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_REG:    f = FMT_R;
      OP_IMM,
      OP_LOAD,
      OP_JALR,
      OP_SYSTEM: f = FMT_I;
      OP_STORE:  f = FMT_S;
      OP_BRANCH: f = FMT_B;
      OP_LUI,
      OP_AUIPC:  f = FMT_U;
      OP_JAL:    f = FMT_J;
      default:   f = FMT_I;
    endcase
    return f;
  endfunction

  function automatic logic op_known(input logic [6:0] op);
    logic k;
    case (op)
      OP_REG, OP_IMM, OP_LOAD, OP_JALR,
      OP_SYSTEM, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL: k = 1'b1;
      default:                  k = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/decode_issue_queue_immdec.sv
// ImmediateDecoder: builds the sign/zero-constructed immediate of an
// instruction, selected by its opcode's format.
module ImmediateDecoder
  import decode_issue_queue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o
);

  logic signed [31:0] imm32;
  fmt_e               fmt;

  assign fmt = op_fmt(instr_i[6:0]);

  always_comb begin
    imm32 = '0;
    unique case (fmt)
      FMT_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25],
                      instr_i[11:7]};
      FMT_B: imm32 = {{19{instr_i[31]}}, instr_i[31],
                      instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
      FMT_U: imm32 = {instr_i[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr_i[31]}}, instr_i[31],
                      instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed cast replicates bit 31 for XLEN above 32.
  assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/decode_issue_queue.sv
// Fetch-to-execute issue queue: buffers {pc, instr}, decodes the
// head's immediate and format, handles flush and counts stalls.
module decode_issue_queue
  import decode_issue_queue_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 2,
  parameter int STALL_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_imm,
  output logic [2:0]               out_fmt,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count,
  output logic [STALL_W-1:0]       stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q,  count_d;
  logic [STALL_W-1:0] stall_q,  stall_d;

  occ_e occ;
  logic push;
  logic pop;
  fmt_e head_fmt;

  always_comb begin
    occ = OCC_PARTIAL;
    if (count_q == '0)
      occ = OCC_EMPTY;
    else if (count_q == CW'(DEPTH))
      occ = OCC_FULL;
  end

  // Neither handshake looks at the partner's ready.
  assign in_ready  = (occ != OCC_FULL) && !flush;
  assign out_valid = (occ != OCC_EMPTY) && !flush;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)
        wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)
        rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    if (out_valid && !out_ready && (stall_q != '1))
      stall_d = stall_q + STALL_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Storage needs no reset; validity lives in count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= in_instr;
      pc_mem[wr_ptr_q]    <= in_pc;
    end
  end

  assign out_instr = instr_mem[rd_ptr_q];
  assign out_pc    = pc_mem[rd_ptr_q];

  ImmediateDecoder #(
    .XLEN(XLEN)
  ) u_immdec (
    .instr_i(out_instr),
    .imm_o  (out_imm)
  );

  assign head_fmt    = op_fmt(out_instr[6:0]);
  assign out_fmt     = head_fmt;
  assign out_illegal = !op_known(out_instr[6:0])
                    || (out_instr[1:0] != 2'b11);

  assign count     = count_q;
  assign stall_cnt = stall_q;

endmodule
